usr_burst_nbit: RTL and testbench
=================================

// Module: usr_burst_nbit
// PURPOSE
//   Parametrised universal shift register, successor to the 1-bit-slice USR array.
//   Adds rotate, arithmetic-right, clear and a multi-step burst engine.
//   The burst engine performs a latched shift/rotate op for a programmed count of
//   cycles, with busy/done handshake. Used as the shift datapath for serial links and CPU.
// PARAMETERS
//   SIZE   8   register width in bits (>=2)
//   AMT_W  4   width of burst step count; max burst = 2**AMT_W-1 steps
// PORTS
//   clk          in   1       single clock, all state updates on posedge
//   rst          in   1       synchronous active-high reset
//   select       in   3       operation code (see BEHAVIOUR)
//   start        in   1       request burst of 'amount' steps using 'select'
//   amount       in   AMT_W   burst step count, sampled with start
//   parallelin   in   SIZE    parallel load data
//   left         in   1       serial in, enters bit 0 on shift toward MSB
//   right        in   1       serial in, enters bit SIZE-1 on shift toward LSB
//   parallelout  out  SIZE    register contents
//   serial_msb   out  1       = parallelout[SIZE-1] (combinational)
//   serial_lsb   out  1       = parallelout[0] (combinational)
//   busy         out  1       high while burst steps are executing
//   done         out  1       one-cycle pulse when a burst completes
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - parallelout=0, busy=0, done=0, state=IDLE.
//   - Overrides everything, including an in-flight burst (abort, no done pulse).
// - select codes (one step = one posedge):
//   - 000 hold.
//   - 001 shift toward LSB: out[i]<=out[i+1], out[SIZE-1]<=right.
//   - 010 shift toward MSB: out[i]<=out[i-1], out[0]<=left.
//   - 011 parallel load: out<=parallelin.
//   - 100 rotate toward LSB: out[SIZE-1]<=out[0].
//   - 101 rotate toward MSB: out[0]<=out[SIZE-1].
//   - 110 arithmetic shift toward LSB: MSB retained.
//   - 111 clear to 0.
// - FSM: IDLE, RUN.
// - IDLE, start=0:
//   - select applied every cycle as a single step (direct USR behaviour).
//   - done=0.
// - IDLE, start=1, select in {001,010,100,101,110}, amount>0:
//   - At this edge E0: latch select and amount into internal regs.
//   - No data change at E0; go to RUN; busy=1 from E0.
// - RUN:
//   - One latched step per edge at E1..En (n=amount).
//   - select/start/amount/parallelin ignored.
//   - left/right sampled live each step.
//   - At En: busy<=0, done<=1, state<=IDLE.
//   - done high exactly the cycle after En; final data valid after En.
//   - Total latency n+1 edges from start.
// - start=1, amount=0, burst-capable select:
//   - No data change, busy stays 0.
//   - done=1 for the cycle after E0.
// - start=1 with select in {000,011,111}:
//   - Executed as a normal single step; no burst, no done.
// - amount may exceed SIZE:
//   - Rotates wrap (SIZE steps = identity).
//   - Shifts fill fully with serial input / sign.
// - start in the done cycle is accepted (state already IDLE).
// - start while busy is ignored, not queued.
// TESTING (SIZE=8, AMT_W=4)
//   T1 rst=1 -> out=0, busy=0, done=0; select=011, pin=8'hA5 -> out=8'hA5 next edge.
//   T2 out=8'h81: select=010,left=1 -> 8'h03; select=001,right=0 -> 8'h40; 111 -> 8'h00.
//   T3 out=8'h81: select=100 -> 8'hC0; out=8'h80, select=110 -> 8'hC0; select=000 -> unchanged.
//   T4 out=8'h01, select=101, amount=3, start 1 cycle -> busy 3 cycles, out 02,04,08, done 1 cycle.
//   T5 amount=0 start -> done next cycle, busy never 1; out=8'h01, 101, amount=9 -> 8'h02.
//   T6 burst amount=5, rst on 2nd busy cycle -> next edge out=0, busy=0, no done; start mid-burst ignored.

Source files
------------

// File: rtl/usr_burst_nbit.sv
// Parametrised universal shift register with rotate, arithmetic shift, clear and
// a multi-step burst engine that repeats a latched op for a programmed count.
module usr_burst_nbit #(
    parameter int SIZE  = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       select,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [SIZE-1:0]  parallelin,
    input  logic             left,
    input  logic             right,
    output logic [SIZE-1:0]  parallelout,
    output logic             serial_msb,
    output logic             serial_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q, op_nx;
    logic [AMT_W-1:0] cnt_q, cnt_nx;
    logic [SIZE-1:0]  data_nx;
    logic             busy_nx, done_nx;

    function automatic logic [SIZE-1:0] step_fn(input logic [2:0] op,
                                                input logic [SIZE-1:0] d,
                                                input logic l,
                                                input logic r);
        case (op)
            3'b001:  step_fn = {r, d[SIZE-1:1]};
            3'b010:  step_fn = {d[SIZE-2:0], l};
            3'b011:  step_fn = parallelin;
            3'b100:  step_fn = {d[0], d[SIZE-1:1]};
            3'b101:  step_fn = {d[SIZE-2:0], d[SIZE-1]};
            3'b110:  step_fn = {d[SIZE-1], d[SIZE-1:1]};
            3'b111:  step_fn = '0;
            default: step_fn = d;
        endcase
    endfunction

    // Only the shift/rotate family can be repeated; hold, load and clear are single-step.
    function automatic logic is_burst(input logic [2:0] op);
        is_burst = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
                   (op == 3'b101) || (op == 3'b110);
    endfunction

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        cnt_nx   = cnt_q;
        data_nx  = parallelout;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start && is_burst(select)) begin
                    if (amount == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        op_nx    = select;
                        cnt_nx   = amount;
                        busy_nx  = 1'b1;
                        state_nx = RUN;
                    end
                end else begin
                    data_nx = step_fn(select, parallelout, left, right);
                end
            end
            RUN: begin
                data_nx = step_fn(op_q, parallelout, left, right);
                cnt_nx  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            parallelout <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            op_q        <= op_nx;
            cnt_q       <= cnt_nx;
            parallelout <= data_nx;
            busy        <= busy_nx;
            done        <= done_nx;
        end
    end

    assign serial_msb = parallelout[SIZE-1];
    assign serial_lsb = parallelout[0];

endmodule

// File: tb/tb_usr_burst_nbit.sv
// Table-driven, scoreboard-checked bench for usr_burst_nbit (SIZE=8, AMT_W=4),
// plus hand-written long bursts exceeding the register width.
module tb_usr_burst_nbit;

    localparam int SIZE  = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       select;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [SIZE-1:0]  parallelin;
    logic             left;
    logic             right;
    logic [SIZE-1:0]  parallelout;
    logic             serial_msb;
    logic             serial_lsb;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    usr_burst_nbit #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .select(select), .start(start), .amount(amount),
        .parallelin(parallelin), .left(left), .right(right),
        .parallelout(parallelout), .serial_msb(serial_msb), .serial_lsb(serial_lsb),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic       start;
        logic [3:0] amt;
        logic [7:0] pin;
        logic       l;
        logic       r;
        logic [7:0] eout;
        logic       ebusy;
        logic       edone;
    } vec_t;

    typedef struct {
        logic [7:0] eout;
        logic       ebusy;
        logic       edone;
    } exp_t;

    vec_t table_q[$];
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic addVec(input logic r_, input logic [2:0] s, input logic st,
                          input logic [3:0] a, input logic [7:0] p, input logic l_,
                          input logic rr, input logic [7:0] eo, input logic eb,
                          input logic ed);
        vec_t v;
        v.rst = r_; v.sel = s; v.start = st; v.amt = a; v.pin = p;
        v.l = l_; v.r = rr; v.eout = eo; v.ebusy = eb; v.edone = ed;
        table_q.push_back(v);
    endtask

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r_, input logic [2:0] s, input logic st,
                         input logic [3:0] a, input logic [7:0] p, input logic l_,
                         input logic rr);
        rst = r_; select = s; start = st; amount = a; parallelin = p;
        left = l_; right = rr;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        drive(v.rst, v.sel, v.start, v.amt, v.pin, v.l, v.r);
        e.eout = v.eout; e.ebusy = v.ebusy; e.edone = v.edone;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            compare($sformatf("vec%0d scoreboard empty", idx), 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            compare($sformatf("vec%0d out", idx), parallelout, e.eout);
            compare($sformatf("vec%0d busy", idx), {7'd0, busy}, {7'd0, e.ebusy});
            compare($sformatf("vec%0d done", idx), {7'd0, done}, {7'd0, e.edone});
            compare($sformatf("vec%0d msb", idx), {7'd0, serial_msb}, {7'd0, e.eout[7]});
            compare($sformatf("vec%0d lsb", idx), {7'd0, serial_lsb}, {7'd0, e.eout[0]});
        end
    endtask

    // Launch a burst, wait (bounded) for done, then check busy length and final data.
    task automatic runBurst(input string name, input logic [2:0] s, input logic [3:0] a,
                            input logic l_, input logic rr, input logic [7:0] eo);
        int  busyCnt = 0;
        logic gotDone = 1'b0;
        drive(1'b0, s, 1'b1, a, 8'h00, l_, rr);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 1'b0, 4'd0, 8'h00, l_, rr);
        for (int c = 0; c < 24; c++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCnt++;
            @(posedge clk);
            #1;
        end
        compare({name, " done seen"}, {7'd0, gotDone}, 8'd1);
        compare({name, " busy cycles"}, 8'(busyCnt), 8'(a));
        compare({name, " final out"}, parallelout, eo);
        @(posedge clk);
        #1;
        compare({name, " done pulse width"}, {7'd0, done}, 8'd0);
    endtask

    initial begin
        drive(1'b1, 3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);

        // rst sel st amt pin l r -> out busy done
        addVec(1, 3'b011, 0, 0, 8'hA5, 0, 0, 8'h00, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        addVec(0, 3'b010, 0, 0, 8'h00, 1, 0, 8'h03, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        addVec(0, 3'b001, 0, 0, 8'h00, 0, 0, 8'h40, 0, 0);
        addVec(0, 3'b111, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        addVec(0, 3'b100, 0, 0, 8'h00, 0, 0, 8'hC0, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0);
        addVec(0, 3'b110, 0, 0, 8'h00, 0, 0, 8'hC0, 0, 0);
        addVec(0, 3'b000, 0, 0, 8'hFF, 1, 1, 8'hC0, 0, 0);
        addVec(0, 3'b001, 0, 0, 8'h00, 0, 1, 8'hE0, 0, 0);
        addVec(0, 3'b101, 0, 0, 8'h00, 0, 0, 8'hC1, 0, 0);
        addVec(0, 3'b010, 0, 0, 8'h00, 0, 0, 8'h82, 0, 0);
        // burst rotate-MSB x3, new load request during RUN must be ignored
        addVec(0, 3'b011, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
        addVec(0, 3'b101, 1, 3, 8'h00, 0, 0, 8'h01, 1, 0);
        addVec(0, 3'b011, 0, 0, 8'hFF, 0, 0, 8'h02, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h04, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h08, 0, 1);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0);
        // zero-length burst, then a 9-step rotate that wraps past the width
        addVec(0, 3'b101, 1, 0, 8'h00, 0, 0, 8'h08, 0, 1);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0);
        addVec(0, 3'b011, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
        addVec(0, 3'b101, 1, 9, 8'h00, 0, 0, 8'h01, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h02, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h04, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h08, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h10, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h20, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h40, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h80, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h02, 0, 1);
        // start during the done cycle is accepted
        addVec(0, 3'b100, 1, 2, 8'h00, 0, 0, 8'h02, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 0, 0, 8'h80, 0, 1);
        // reset aborts a burst; start while busy is ignored
        addVec(0, 3'b011, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        addVec(0, 3'b010, 1, 5, 8'h00, 1, 0, 8'h00, 1, 0);
        addVec(0, 3'b111, 1, 3, 8'h00, 1, 0, 8'h01, 1, 0);
        addVec(1, 3'b000, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        addVec(0, 3'b000, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            checkOutput(i);
        end

        runBurst("shr12", 3'b001, 4'd12, 1'b0, 1'b1, 8'hFF);
        runBurst("shl10", 3'b010, 4'd10, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 3'b011, 1'b0, 4'd0, 8'h80, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        runBurst("asr15", 3'b110, 4'd15, 1'b0, 1'b0, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
